// File: rtl/aes_round_key_gen.sv
// Sequential AES-128 key expander: emits round keys k0..k(NUM_ROUNDS) one at a time over a
// valid/ready handshake, deriving each key from the previous one on the fly.
module aes_round_key_gen #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPresent = 2'd1;
  localparam logic [1:0] StExpand  = 2'd2;

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [1:0]   state_q, state_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic [3:0]   rk_round_q, rk_round_d;
  logic         done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, tmp_w;
  logic [31:0] n0, n1, n2, n3;
  logic [127:0] next_key;

  assign w0 = rk_out_q[127:96];
  assign w1 = rk_out_q[95:64];
  assign w2 = rk_out_q[63:32];
  assign w3 = rk_out_q[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};
  assign sub_w = {Sbox[rot_w[31:24]], Sbox[rot_w[23:16]], Sbox[rot_w[15:8]], Sbox[rot_w[7:0]]};
  // rcon is indexed by the round being produced, one past the key currently held
  assign tmp_w = sub_w ^ {rcon(rk_round_q + 4'd1), 24'h0};

  assign n0 = w0 ^ tmp_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d    = state_q;
    rk_out_d   = rk_out_q;
    rk_round_d = rk_round_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (key_load) begin
          rk_out_d   = key_in;
          rk_round_d = 4'd0;
          state_d    = StPresent;
        end
      end
      StPresent: begin
        if (rk_ready) begin
          if (rk_round_q == LastRound) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StExpand;
          end
        end
      end
      StExpand: begin
        rk_out_d   = next_key;
        rk_round_d = rk_round_q + 4'd1;
        state_d    = StPresent;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rk_out_q   <= '0;
      rk_round_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_out_q   <= rk_out_d;
      rk_round_q <= rk_round_d;
      done_q     <= done_d;
    end
  end

  // All outputs come straight from flops, so rk_ready never reaches an output combinationally
  assign busy     = (state_q != StIdle);
  assign rk_valid = (state_q == StPresent);
  assign rk_out   = rk_out_q;
  assign rk_round = rk_round_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Bench for aes_round_key_gen: a full-schedule FIPS-197 model drives a per-cycle compare of two
// instances (full schedule and NUM_ROUNDS=2) plus directed literal checks.
module tb_aes_round_key_gen;

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FipsK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroK1  = 128'h62636363626363636263636362636363;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rst_v = 2'b11;
  logic [1:0]   key_load_v = 2'b00;
  logic [1:0]   rk_ready_v = 2'b00;
  logic [1:0]   busy_v, rk_valid_v, done_v;
  logic [127:0] key_in_v [2];
  logic [127:0] rk_out_v [2];
  logic [3:0]   rk_round_v [2];

  aes_round_key_gen #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst_v[0]), .key_in(key_in_v[0]), .key_load(key_load_v[0]),
    .busy(busy_v[0]), .rk_valid(rk_valid_v[0]), .rk_ready(rk_ready_v[0]),
    .rk_out(rk_out_v[0]), .rk_round(rk_round_v[0]), .done(done_v[0])
  );

  aes_round_key_gen #(.NUM_ROUNDS(2)) dut2 (
    .clk(clk), .rst(rst_v[1]), .key_in(key_in_v[1]), .key_load(key_load_v[1]),
    .busy(busy_v[1]), .rk_valid(rk_valid_v[1]), .rk_ready(rk_ready_v[1]),
    .rk_out(rk_out_v[1]), .rk_round(rk_round_v[1]), .done(done_v[1])
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference S-box built from GF(2^8) inversion and the affine map
  logic [7:0] sb [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    return t[15-n -: 8];
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook word-array expansion; returns round key r of cipher key k
  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Cycle model state per instance
  logic         m_active [2] = '{1'b0, 1'b0};
  logic         m_valid  [2] = '{1'b0, 1'b0};
  logic         m_done   [2] = '{1'b0, 1'b0};
  int           m_idx    [2] = '{0, 0};
  logic [127:0] m_out    [2] = '{128'h0, 128'h0};
  logic [127:0] m_key    [2] = '{128'h0, 128'h0};
  int           dut_acc  [2] = '{0, 0};
  int           dut_done [2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int nr;
      logic nd;
      nr = (d == 0) ? 10 : 2;
      chk($sformatf("mon%0d_busy", d), 128'(busy_v[d]), 128'(m_active[d]));
      chk($sformatf("mon%0d_valid", d), 128'(rk_valid_v[d]), 128'(m_valid[d]));
      chk($sformatf("mon%0d_done", d), 128'(done_v[d]), 128'(m_done[d]));
      chk($sformatf("mon%0d_round", d), 128'(rk_round_v[d]), 128'(m_idx[d]));
      chk($sformatf("mon%0d_out", d), rk_out_v[d], m_out[d]);
      if (rk_valid_v[d] && rk_ready_v[d]) dut_acc[d]++;
      if (done_v[d]) dut_done[d]++;
      if (rst_v[d]) begin
        m_active[d] = 1'b0; m_valid[d] = 1'b0; m_done[d] = 1'b0;
        m_idx[d] = 0; m_out[d] = '0;
      end else begin
        nd = 1'b0;
        if (!m_active[d]) begin
          if (key_load_v[d]) begin
            m_key[d] = key_in_v[d]; m_active[d] = 1'b1; m_valid[d] = 1'b1;
            m_idx[d] = 0; m_out[d] = key_in_v[d];
          end
        end else if (m_valid[d]) begin
          if (rk_ready_v[d]) begin
            m_valid[d] = 1'b0;
            if (m_idx[d] == nr) begin
              m_active[d] = 1'b0;
              nd = 1'b1;
            end
          end
        end else begin
          m_idx[d]++;
          m_out[d] = round_key(m_key[d], m_idx[d]);
          m_valid[d] = 1'b1;
        end
        m_done[d] = nd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    rst_v[d] = 1'b1;
    tick();
    rst_v[d] = 1'b0;
  endtask

  task automatic load(input int d, input logic [127:0] k);
    key_in_v[d] = k;
    key_load_v[d] = 1'b1;
    tick();
    key_load_v[d] = 1'b0;
  endtask

  task automatic run_to_done(input int d, input int bound, input logic rnd);
    int c = 0;
    while (!done_v[d] && c < bound) begin
      if (rnd) rk_ready_v[d] = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    if (!done_v[d]) chk("done_timeout", 128'(done_v[d]), 128'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0, done0;
    key_in_v[0] = '0;
    key_in_v[1] = '0;
    build_sbox();
    chk("model_sbox00", 128'(sb[8'h00]), 128'h63);
    chk("model_sbox53", 128'(sb[8'h53]), 128'hed);
    chk("model_fips_k1", round_key(FipsKey, 1), FipsK1);
    chk("model_fips_k2", round_key(FipsKey, 2), FipsK2);
    chk("model_fips_k10", round_key(FipsKey, 10), FipsK10);
    chk("model_zero_k1", round_key(128'h0, 1), ZeroK1);

    tick();
    rst_v = 2'b00;
    chk("reset_busy", 128'(busy_v[0]), 128'd0);
    chk("reset_valid", 128'(rk_valid_v[0]), 128'd0);
    chk("reset_out", rk_out_v[0], 128'h0);

    // FIPS-197 schedule, consumer always ready
    rk_ready_v[0] = 1'b1;
    load(0, FipsKey);
    chk("fips_p1_valid", 128'(rk_valid_v[0]), 128'd1);
    chk("fips_p1_round", 128'(rk_round_v[0]), 128'd0);
    chk("fips_p1_out", rk_out_v[0], FipsKey);
    tick(); tick();
    chk("fips_p3_round", 128'(rk_round_v[0]), 128'd1);
    chk("fips_p3_out", rk_out_v[0], FipsK1);
    repeat (18) tick();
    chk("fips_p21_round", 128'(rk_round_v[0]), 128'd10);
    chk("fips_p21_out", rk_out_v[0], FipsK10);
    tick();
    chk("fips_p22_done", 128'(done_v[0]), 128'd1);
    chk("fips_p22_busy", 128'(busy_v[0]), 128'd0);
    tick();
    chk("fips_p23_done", 128'(done_v[0]), 128'd0);

    // Backpressure at round 1
    do_reset(0);
    load(0, FipsKey);
    tick(); tick();
    rk_ready_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 128'(rk_valid_v[0]), 128'd1);
      chk("bp_out", rk_out_v[0], FipsK1);
    end
    rk_ready_v[0] = 1'b1;
    tick(); tick();
    chk("bp_round2", 128'(rk_round_v[0]), 128'd2);
    chk("bp_out2", rk_out_v[0], FipsK2);
    run_to_done(0, 100, 1'b0);

    // Load pulse while busy is ignored
    do_reset(0);
    load(0, FipsKey);
    repeat (8) tick();
    chk("lb_round4", 128'(rk_round_v[0]), 128'd4);
    load(0, 128'h0);
    run_to_done(0, 100, 1'b0);
    chk("lb_final_out", rk_out_v[0], FipsK10);
    chk("lb_final_round", 128'(rk_round_v[0]), 128'd10);

    // Reset during the expand step into round 7
    do_reset(0);
    load(0, FipsKey);
    repeat (12) tick();
    chk("mr_round6", 128'(rk_round_v[0]), 128'd6);
    tick();
    chk("mr_expand_valid", 128'(rk_valid_v[0]), 128'd0);
    do_reset(0);
    chk("mr_valid", 128'(rk_valid_v[0]), 128'd0);
    chk("mr_busy", 128'(busy_v[0]), 128'd0);
    chk("mr_out", rk_out_v[0], 128'h0);
    load(0, 128'h0);
    tick(); tick();
    chk("mr_zero_k1", rk_out_v[0], ZeroK1);
    run_to_done(0, 100, 1'b0);

    // Random keys with random stalls; the monitor checks every key against the model
    tick();
    acc0 = dut_acc[0];
    done0 = dut_done[0];
    for (int n = 0; n < 200; n++) begin
      load(0, {$urandom, $urandom, $urandom, $urandom});
      run_to_done(0, 1000, 1'b1);
    end
    tick();
    chk("rnd_accepts", 128'(dut_acc[0] - acc0), 128'd2200);
    chk("rnd_dones", 128'(dut_done[0] - done0), 128'd200);

    // Truncated schedule on the NUM_ROUNDS=2 instance
    do_reset(1);
    rk_ready_v[1] = 1'b1;
    load(1, FipsKey);
    repeat (4) tick();
    chk("nr2_round2", 128'(rk_round_v[1]), 128'd2);
    chk("nr2_out2", rk_out_v[1], FipsK2);
    tick();
    chk("nr2_done", 128'(done_v[1]), 128'd1);
    chk("nr2_busy", 128'(busy_v[1]), 128'd0);
    repeat (4) tick();
    chk("nr2_no_expand", 128'(rk_round_v[1]), 128'd2);
    chk("nr2_accepts", 128'(dut_acc[1]), 128'd3);
    chk("nr2_dones", 128'(dut_done[1]), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_key_gen.md
Name: aes_round_key_gen

Overview:
- Sequential AES-128 key expander. Takes a 128-bit cipher key and produces round keys k0..k10 one at a time over a valid/ready stream.
- Sits beside the round datapath. Its rk_out feeds the AddRoundKey stage, which XORs it with the 128-bit column-packed state leaving the MixColumns stage.
- Round keys are computed on the fly. Nothing is stored beyond the current key.

Parameters:
- NUM_ROUNDS, 10: index of the last round key emitted. Legal range 1..10; 10 is full AES-128. Values below 10 truncate the schedule for bench use only.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  128  cipher key. Word w0 = key_in[127:96] … w3 = key_in[31:0]; byte 0 of each word in bits [31:24].
- key_load  input  1  start pulse. Sampled only in IDLE.
- busy  output  1  high in any state other than IDLE.
- rk_valid  output  1  rk_out/rk_round hold a valid round key.
- rk_ready  input  1  consumer accepts the key this cycle.
- rk_out  output  128  current round key, same word/byte packing as key_in.
- rk_round  output  4  index of rk_out, 0..NUM_ROUNDS.
- done  output  1  one-cycle pulse after the final key is accepted.

Behaviour:
- Reset (rst=1 at a clock edge, in any state, including mid-schedule): state=IDLE, busy=0, rk_valid=0, rk_out=0, rk_round=0, done=0. Reset has priority over every other input.
- States: IDLE, PRESENT, EXPAND.
- IDLE:
  - busy=0.
  - If key_load=1: rk_out<=key_in, rk_round<=0, rk_valid<=1, go to PRESENT.
  - Latency from key_load to rk_valid is 1 cycle.
- PRESENT:
  - rk_valid=1. rk_out and rk_round are held stable while rk_ready=0 (unbounded backpressure).
  - On rk_valid&rk_ready with rk_round==NUM_ROUNDS: rk_valid<=0, done<=1 for exactly one cycle, go to IDLE. rk_out and rk_round retain their last values.
  - On rk_valid&rk_ready otherwise: rk_valid<=0, go to EXPAND.
- EXPAND (exactly 1 cycle, rk_valid=0):
  - rk_out<=next(rk_out), rk_round<=rk_round+1, rk_valid<=1, go to PRESENT.
  - Throughput with rk_ready tied high: one key every 2 cycles. 11 keys take 21 cycles from the first rk_valid to the final accept.
- key_load while busy=1 is ignored. It does not restart, corrupt, or queue.
- key_load in the same cycle as the final accept is also ignored. The block re-enters IDLE, and a new load requires a pulse while busy=0.
- next(k), with w0..w3 = words of k and r = rk_round+1:
  - rot = {w3[23:0], w3[31:24]}.
  - sub = AES S-box applied bytewise to rot. The S-box is a 256-entry forward lookup inside this block, 4 instances, combinational.
  - temp = sub ^ {rcon(r), 24'h0}.
  - rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36.
  - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- done is low in every cycle other than the pulse. busy is deasserted in the same cycle done is high.
- No combinational path from rk_ready to any output.

Test Plan:
- FIPS-197 key: rst, then key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1.
  - Cycle +1: rk_round=0, rk_out=key.
  - Cycle +3: rk_round=1, rk_out=a0fafe1788542cb123a339392a6c7605.
  - Cycle +21: rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Cycle +22: done=1, busy=0.
- Backpressure: same key with rk_ready=0 for 5 cycles at rk_round=1 → rk_out stays a0fafe17…7605 with rk_valid=1 throughout. Releasing ready gives rk_round=2, rk_out=f2c295f27a96b9435935807a7359f67f.
- Load while busy: key_in=000…0 pulsed at rk_round=4 → ignored. The schedule continues with FIPS key values through round 10 unchanged.
- Reset mid-operation: rst=1 during EXPAND of round 6 → next cycle rk_valid=0, busy=0, rk_out=0. A subsequent key_load of the all-zero key gives k1=62636363626363636263636362636363.
- Random regression: 200 random keys with random rk_ready stalls (50% duty), all 11 keys checked against a reference model. Each accepted key appears exactly once, in order 0..10, with exactly one done pulse per load.
- NUM_ROUNDS=2: FIPS key → exactly 3 keys accepted (rk_round 0, 1, 2), then done. No EXPAND occurs after round 2.
